param_counter: RTL and testbench
================================

PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; legal range 2..32.
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1: terminal (largest) count value; legal range 1..2**WIDTH-1.
REQ-003 Parameter SATURATE, default 0: 0 = wrap at limits, 1 = hold at limits.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-006 en  input  1  count enable; count steps by one per cycle while high.
REQ-007 up_dn  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 load  input  1  synchronous parallel load strobe.
REQ-009 load_val  input  WIDTH  value captured when load is high.
REQ-010 count  output  WIDTH  registered counter value.
REQ-011 tc  output  1  combinational terminal-count flag, valid in the same cycle as count.
REQ-012 wrap  output  1  registered one-cycle pulse that marks a wrap event.
REQ-013 sat  output  1  registered flag that marks a step blocked at a limit (SATURATE=1 only).

Function
REQ-014 The counter SHALL apply this per-edge priority: reset, then load, then en, then hold.
REQ-015 When load=1, count SHALL take the value min(load_val, MAX_VAL) on the next edge, whatever the values of en and up_dn.
REQ-016 When load=1, wrap and sat SHALL be 0 on the next edge.
REQ-017 When en=1, up_dn=1 and count<MAX_VAL, count SHALL increase by 1 on the next edge.
REQ-018 When en=1, up_dn=0 and count>0, count SHALL decrease by 1 on the next edge.
REQ-019 When en=1, up_dn=1, count=MAX_VAL and SATURATE=0, count SHALL go to 0 and wrap SHALL be 1 for exactly that following cycle.
REQ-020 When en=1, up_dn=0, count=0 and SATURATE=0, count SHALL go to MAX_VAL and wrap SHALL be 1 for exactly that following cycle.
REQ-021 When SATURATE=1 and a step would cross a limit, count SHALL hold, sat SHALL be 1 for that following cycle, and wrap SHALL stay 0.
REQ-022 When en=0 and load=0, count SHALL hold, and wrap and sat SHALL be 0 on the next edge.
REQ-023 tc SHALL be 1 exactly when (up_dn=1 and count=MAX_VAL) or (up_dn=0 and count=0), regardless of en.
REQ-024 Count arithmetic SHALL be WIDTH bits wide, and count SHALL never hold a value greater than MAX_VAL.
REQ-025 A direction change SHALL take effect on the same edge it is sampled; no turnaround cycle is inserted.
REQ-026 Latency SHALL be 1 cycle from an input edge to the count, wrap or sat update.

Reset
REQ-027 When rst=0 at a rising edge of clk, count, wrap and sat SHALL all be 0 after that edge, overriding load and en.
REQ-028 Reset SHALL have no asynchronous path; a rst pulse that lies between edges SHALL have no effect.
REQ-029 A reset asserted mid-count or during a wrap cycle SHALL clear the wrap pulse on the same edge.
REQ-030 The first count step after reset release SHALL occur on the first edge at which rst=1 and en=1.

Verification (WIDTH=4, MAX_VAL=9 unless stated)
REQ-031 Hold rst=0 for 2 edges with en=1 and load=1, load_val=5, then release -> count=0, wrap=0 and sat=0 while in reset; count=1 one edge after release with en=1, up_dn=1.
REQ-032 Up-count from 0 with en=1 for 10 edges -> count runs 1..9 then 0; tc=1 while count=9; wrap=1 only in the cycle where count=0.
REQ-033 Down-count from 0 with SATURATE=0 -> count=9 with wrap=1; then with SATURATE=1 from 0 -> count stays 0, sat=1, wrap=0.
REQ-034 load=1, load_val=14 together with en=1 -> count=9, the value clamped to MAX_VAL; the next enabled up step gives 0 with wrap=1.
REQ-035 At count=9 with up_dn=1, drop up_dn to 0 in the same cycle as en=1 -> count=8, wrap=0; tc goes 1 then 0 combinationally.
REQ-036 Assert rst=0 in the cycle where wrap=1, and run WIDTH=8 with default MAX_VAL for 256 up steps -> reset clears wrap immediately; the 8-bit run wraps 255 to 0 with a single wrap pulse.

Source files
------------

// File: rtl/param_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : param_counter
//  Function : Parameterised up/down counter with parallel load, terminal-count
//             flag, wrap pulse and optional saturation at the count limits.
//  Revision : 1.0  initial release
// ============================================================================
module param_counter #(
   parameter int unsigned           WIDTH    = 4,
   parameter logic [WIDTH-1:0]      MAX_VAL  = {WIDTH{1'b1}},
   parameter bit                    SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             sat
);

   localparam logic [WIDTH-1:0] c_zero = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q,  wrap_d;
   logic             sat_q,   sat_d;

   logic             w_at_max;
   logic             w_at_min;
   logic [WIDTH-1:0] w_load_clamped;

   // Limit detection; >= keeps the upper test safe even if the count were ever corrupted.
   assign w_at_max       = (count_q >= MAX_VAL);
   assign w_at_min       = (count_q == c_zero);
   assign w_load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

   // Next-state selection: load beats enable, enable beats hold; flags default low.
   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      sat_d   = 1'b0;
      if (load) begin
         count_d = w_load_clamped;
      end else if (en) begin
         if (up_dn) begin
            if (w_at_max) begin
               if (SATURATE) begin
                  sat_d = 1'b1;
               end else begin
                  count_d = c_zero;
                  wrap_d  = 1'b1;
               end
            end else begin
               count_d = count_q + c_one;
            end
         end else begin
            if (w_at_min) begin
               if (SATURATE) begin
                  sat_d = 1'b1;
               end else begin
                  count_d = MAX_VAL;
                  wrap_d  = 1'b1;
               end
            end else begin
               count_d = count_q - c_one;
            end
         end
      end
   end

   // State register with synchronous active-low reset overriding load and enable.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q <= c_zero;
         wrap_q  <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
         sat_q   <= sat_d;
      end
   end

   assign count = count_q;
   assign wrap  = wrap_q;
   assign sat   = sat_q;
   // Terminal count follows the live direction input, independent of enable.
   assign tc    = (up_dn && w_at_max) || (!up_dn && w_at_min);

endmodule
`default_nettype wire

// File: tb/tb_param_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_param_counter
//  Function : Self-checking bench for param_counter. Three instances share the
//             stimulus: 4-bit/max 9 wrapping, 4-bit/max 9 saturating and
//             8-bit default-max wrapping.
//  Revision : 1.0  initial release
// ============================================================================
module tb_param_counter;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       up_dn;
   logic       load;
   logic [7:0] load_val;

   logic [3:0] c0, c1;
   logic [7:0] c2;
   logic       tc0, tc1, tc2;
   logic       w0, w1, w2;
   logic       s0, s1, s2;

   int ncmp = 0;
   int nerr = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   param_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) u_wrap4 (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val[3:0]), .count(c0), .tc(tc0), .wrap(w0), .sat(s0));

   param_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)) u_sat4 (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val[3:0]), .count(c1), .tc(tc1), .wrap(w1), .sat(s1));

   param_counter #(.WIDTH(8)) u_wrap8 (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .count(c2), .tc(tc2), .wrap(w2), .sat(s2));

   // ---------------- reference model (rule-level arithmetic) ----------------
   int m_max [3] = '{9, 9, 255};
   bit m_satm[3] = '{1'b0, 1'b1, 1'b0};
   int m_cnt [3] = '{0, 0, 0};
   bit m_wrap[3] = '{1'b0, 1'b0, 1'b0};
   bit m_sat [3] = '{1'b0, 1'b0, 1'b0};

   function automatic int f_cnt(int c, int mx, bit sm, bit r, bit ld, int lv, bit e, bit u);
      if (!r)  return 0;
      if (ld)  return (lv > mx) ? mx : lv;
      if (!e)  return c;
      if (u)   return (c == mx) ? (sm ? c : 0) : c + 1;
      return (c == 0) ? (sm ? c : mx) : c - 1;
   endfunction

   function automatic bit f_limit(int c, int mx, bit r, bit ld, bit e, bit u);
      if (!r || ld || !e) return 1'b0;
      return u ? (c == mx) : (c == 0);
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         int lv;
         lv = (i == 2) ? int'(load_val) : int'(load_val[3:0]);
         m_cnt[i]  <= f_cnt(m_cnt[i], m_max[i], m_satm[i], rst, load, lv, en, up_dn);
         m_wrap[i] <= f_limit(m_cnt[i], m_max[i], rst, load, en, up_dn) && !m_satm[i];
         m_sat[i]  <= f_limit(m_cnt[i], m_max[i], rst, load, en, up_dn) &&  m_satm[i];
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Every-cycle compare against the model, 2ns after the rising edge.
   always @(posedge clk) begin
      #2;
      if (chk_en) begin
         int ac[3];
         bit at[3], aw[3], as_[3];
         ac = '{int'(c0), int'(c1), int'(c2)};
         at = '{tc0, tc1, tc2};
         aw = '{w0, w1, w2};
         as_ = '{s0, s1, s2};
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("m_count[%0d]", i), ac[i], m_cnt[i]);
            chk($sformatf("m_wrap[%0d]", i), int'(aw[i]), int'(m_wrap[i]));
            chk($sformatf("m_sat[%0d]", i), int'(as_[i]), int'(m_sat[i]));
            chk($sformatf("m_tc[%0d]", i), int'(at[i]),
                int'((up_dn && m_cnt[i] == m_max[i]) || (!up_dn && m_cnt[i] == 0)));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #3;
   endtask

   // Mixed directed vectors: {load, en, up_dn, load_val}
   logic [10:0] vec [8] = '{
      {1'b1, 1'b0, 1'b1, 8'd7},
      {1'b0, 1'b1, 1'b1, 8'd0},
      {1'b0, 1'b1, 1'b1, 8'd0},
      {1'b0, 1'b1, 1'b0, 8'd0},
      {1'b1, 1'b1, 1'b0, 8'd200},
      {1'b0, 1'b1, 1'b0, 8'd0},
      {1'b0, 1'b0, 1'b0, 8'd0},
      {1'b1, 1'b1, 1'b1, 8'd0}
   };

   initial begin
      int wraps;
      rst = 1'b0; en = 1'b1; load = 1'b1; load_val = 8'd5; up_dn = 1'b1;
      cyc();
      chk_en = 1'b1;
      chk("rst_count", int'(c0), 0);
      chk("rst_wrap",  int'(w0), 0);
      chk("rst_sat",   int'(s1), 0);
      cyc();
      chk("rst_count2", int'(c0), 0);
      rst = 1'b1; load = 1'b0;
      cyc();
      chk("first_step", int'(c0), 1);

      // Up-count through the wrap
      load = 1'b1; load_val = 8'd0;
      cyc();
      load = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         cyc();
         chk($sformatf("up_count_%0d", k), int'(c0), k % 10);
         chk($sformatf("up_wrap_%0d", k), int'(w0), (k == 10) ? 1 : 0);
         if (k == 9) chk("up_tc_at_9", int'(tc0), 1);
      end

      // Down from zero: wrap vs. saturate
      load = 1'b1; load_val = 8'd0; en = 1'b0;
      cyc();
      load = 1'b0; en = 1'b1; up_dn = 1'b0;
      cyc();
      chk("dn_wrap_count", int'(c0), 9);
      chk("dn_wrap_flag",  int'(w0), 1);
      chk("dn_sat_count",  int'(c1), 0);
      chk("dn_sat_flag",   int'(s1), 1);
      chk("dn_sat_nowrap", int'(w1), 0);

      // Clamped load, then wrap from the clamped value
      load = 1'b1; load_val = 8'd14; en = 1'b1; up_dn = 1'b1;
      cyc();
      chk("clamp_count", int'(c0), 9);
      chk("clamp_8bit",  int'(c2), 14);
      load = 1'b0;
      cyc();
      chk("clamp_wrap_count", int'(c0), 0);
      chk("clamp_wrap_flag",  int'(w0), 1);
      chk("clamp_sat_hold",   int'(c1), 9);

      // Direction change at the top
      load = 1'b1; load_val = 8'd9; en = 1'b0;
      cyc();
      load = 1'b0;
      chk("dir_tc_up", int'(tc0), 1);
      up_dn = 1'b0;
      #1;
      chk("dir_tc_dn", int'(tc0), 0);
      en = 1'b1;
      cyc();
      chk("dir_count", int'(c0), 8);
      chk("dir_wrap",  int'(w0), 0);

      // Reset during the wrap cycle
      load = 1'b1; load_val = 8'd9; en = 1'b0; up_dn = 1'b1;
      cyc();
      load = 1'b0; en = 1'b1;
      cyc();
      chk("pre_rst_wrap", int'(w0), 1);
      rst = 1'b0;
      cyc();
      chk("rst_clears_wrap",  int'(w0), 0);
      chk("rst_clears_count", int'(c0), 0);
      rst = 1'b1;

      // Hold with enable low
      load = 1'b1; load_val = 8'd3; en = 1'b0;
      cyc();
      load = 1'b0;
      repeat (3) cyc();
      chk("hold_count", int'(c0), 3);

      // Reset glitch between edges is ignored
      en = 1'b1; up_dn = 1'b1;
      rst = 1'b0;
      #1;
      rst = 1'b1;
      cyc();
      chk("rst_glitch", int'(c0), 4);

      foreach (vec[i]) begin
         {load, en, up_dn, load_val} = vec[i];
         cyc();
      end

      // 8-bit full-range run
      rst = 1'b0; load = 1'b0; en = 1'b1; up_dn = 1'b1;
      cyc();
      rst = 1'b1;
      wraps = 0;
      for (int k = 0; k < 256; k++) begin
         cyc();
         if (w2) wraps++;
      end
      chk("w8_final_count", int'(c2), 0);
      chk("w8_wrap_pulses", wraps, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
